// File: rtl/led_seq_ctrl_if.sv
// Command channel for led_seq_ctrl: requester presents mode/len with valid,
// the block answers with ready.
interface led_seq_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [7:0] cmd_len;

  modport master (output cmd_valid, output cmd_mode, output cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_mode, input cmd_len, output cmd_ready);
endinterface

// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: accepts a mode/length command, steps a 4-bit pattern
// once every TICK_DIV clocks, and freezes the last pattern when the run ends.
// Every output is a flop; the comb block computes next values for all of them.
module led_seq_ctrl #(
  parameter int TICK_DIV = 100000
) (
  input  logic          clk,
  input  logic          reset,
  led_seq_ctrl_if.slave cmd,
  input  logic          stop,
  output logic          busy,
  output logic          done,
  output logic [3:0]    led
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  localparam logic [1:0] M_DARK   = 2'd0;
  localparam logic [1:0] M_COUNT  = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;
  localparam logic [1:0] M_BLINK  = 2'd3;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      step_q,  step_d;
  logic            dir_q,   dir_d;    // 0 = shifting left, 1 = shifting right
  logic [1:0]      mode_q,  mode_d;
  logic [7:0]      len_q,   len_d;
  logic [3:0]      led_q,   led_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;
  logic            ready_q, ready_d;

  logic tick;
  logic accept;

  assign tick   = (state_q == S_RUN) && (presc_q == TICK_LAST);
  assign accept = cmd.cmd_valid && ready_q;

  assign cmd.cmd_ready = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign led           = led_q;

  function automatic logic [3:0] init_pat(input logic [1:0] m);
    case (m)
      M_BOUNCE: init_pat = 4'b0001;
      M_BLINK:  init_pat = 4'b1111;
      default:  init_pat = 4'b0000;
    endcase
  endfunction

  // State and datapath registers; reset drops everything to the idle picture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      step_q  <= '0;
      dir_q   <= 1'b0;
      mode_q  <= '0;
      len_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // Next-state and next-output logic; stop outranks accept and stepping.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    step_d  = step_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    len_d   = len_q;
    led_d   = led_q;
    done_d  = 1'b0;

    case (state_q)
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          led_d   = 4'b0000;
        end else begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            // Counter saturates so an endless run never wraps into a false match.
            step_d = (step_q == 8'hFF) ? step_q : step_q + 8'd1;
            case (mode_q)
              M_DARK:  led_d = 4'b0000;
              M_COUNT: led_d = led_q + 4'd1;
              M_BOUNCE: begin
                if (!dir_q) begin
                  led_d = {led_q[2:0], 1'b0};
                  if (led_q == 4'b0100) dir_d = 1'b1;
                end else begin
                  led_d = {1'b0, led_q[3:1]};
                  if (led_q == 4'b0010) dir_d = 1'b0;
                end
              end
              M_BLINK: led_d = ~led_q;
              default: led_d = led_q;
            endcase
            // This tick is step number step_q+1; finish when it equals len.
            if ((len_q != 8'd0) && (step_q == len_q - 8'd1)) begin
              state_d = S_HOLD;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: begin
        if ((state_q == S_HOLD) && stop) begin
          state_d = S_IDLE;
          led_d   = 4'b0000;
        end else if (accept) begin
          state_d = S_RUN;
          mode_d  = cmd.cmd_mode;
          len_d   = cmd.cmd_len;
          presc_d = '0;
          step_d  = '0;
          dir_d   = 1'b0;
          led_d   = init_pat(cmd.cmd_mode);
        end
      end
    endcase

    busy_d  = (state_d == S_RUN);
    ready_d = (state_d != S_RUN);
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: two instances (TICK_DIV 4 and 1) checked every
// cycle against a closed-form model (pattern = f(mode, edges since accept / TICK_DIV)),
// plus literal expectations at hand-computed points.
module tb_led_seq_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  led_seq_ctrl_if if0();
  led_seq_ctrl_if if1();

  logic       vld[2];
  logic [1:0] md[2];
  logic [7:0] ln[2];
  logic       stp[2];
  logic       rdy[2];
  logic       dbusy[2];
  logic       ddone[2];
  logic [3:0] dled[2];

  assign if0.cmd_valid = vld[0];
  assign if0.cmd_mode  = md[0];
  assign if0.cmd_len   = ln[0];
  assign rdy[0]        = if0.cmd_ready;
  assign if1.cmd_valid = vld[1];
  assign if1.cmd_mode  = md[1];
  assign if1.cmd_len   = ln[1];
  assign rdy[1]        = if1.cmd_ready;

  led_seq_ctrl #(.TICK_DIV(4)) u_d4 (
    .clk(clk), .reset(reset), .cmd(if0.slave), .stop(stp[0]),
    .busy(dbusy[0]), .done(ddone[0]), .led(dled[0]));

  led_seq_ctrl #(.TICK_DIV(1)) u_d1 (
    .clk(clk), .reset(reset), .cmd(if1.slave), .stop(stp[1]),
    .busy(dbusy[1]), .done(ddone[1]), .led(dled[1]));

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string nm, input int i, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s dut%0d at %0t: got %0d expected %0d", nm, i, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int         td[2] = '{4, 1};
  int         mst[2];          // 0 idle, 1 run, 2 hold
  int         t0[2];
  int         mmode[2];
  int         mlen[2];
  logic [3:0] mled[2];
  logic       mdone[2];
  int         ecnt;

  function automatic logic [3:0] pat(input int m, input int k);
    logic [3:0] b[6];
    b = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};
    case (m)
      1:       pat = 4'(k % 16);
      2:       pat = b[k % 6];
      3:       pat = (k % 2 == 0) ? 4'b1111 : 4'b0000;
      default: pat = 4'b0000;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        mst[i]   <= 0;
        mled[i]  <= 4'b0000;
        mdone[i] <= 1'b0;
        t0[i]    <= 0;
        mmode[i] <= 0;
        mlen[i]  <= 0;
      end
      ecnt <= 0;
    end else begin
      ecnt <= ecnt + 1;
      for (int i = 0; i < 2; i++) begin
        int k;
        k = (ecnt + 1 - t0[i]) / td[i];
        mdone[i] <= 1'b0;
        if (mst[i] == 1) begin
          if (stp[i]) begin
            mst[i]  <= 0;
            mled[i] <= 4'b0000;
          end else begin
            mled[i] <= pat(mmode[i], k);
            if (mlen[i] != 0 && k == mlen[i]) begin
              mst[i]   <= 2;
              mdone[i] <= 1'b1;
            end
          end
        end else if (mst[i] == 2 && stp[i]) begin
          mst[i]  <= 0;
          mled[i] <= 4'b0000;
        end else if (vld[i]) begin
          mst[i]   <= 1;
          t0[i]    <= ecnt + 1;
          mmode[i] <= int'(md[i]);
          mlen[i]  <= int'(ln[i]);
          mled[i]  <= pat(int'(md[i]), 0);
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        chk("m_led",   i, int'(dled[i]),  int'(mled[i]));
        chk("m_busy",  i, int'(dbusy[i]), (mst[i] == 1) ? 1 : 0);
        chk("m_ready", i, int'(rdy[i]),   (mst[i] != 1) ? 1 : 0);
        chk("m_done",  i, int'(ddone[i]), int'(mdone[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input int i);
    int b;
    b = 0;
    while (!rdy[i] && b < 200) begin
      cyc(1);
      b++;
    end
    if (!rdy[i]) begin
      ntot++;
      $display("FAIL ready_timeout dut%0d: cmd_ready still %0d after %0d cycles, expected 1", i, rdy[i], b);
    end
  endtask

  task automatic send(input int i, input int m, input int l);
    vld[i] = 1'b1;
    md[i]  = 2'(m);
    ln[i]  = 8'(l);
    wait_ready(i);
    cyc(1);
    vld[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; md[i] = 2'd0; ln[i] = 8'd0; stp[i] = 1'b0;
    end
    cyc(2);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_led",   i, int'(dled[i]),  0);
      chk("rst_busy",  i, int'(dbusy[i]), 0);
      chk("rst_ready", i, int'(rdy[i]),   1);
      chk("rst_done",  i, int'(ddone[i]), 0);
    end
    cyc(1);

    // mode 1, len 5, TICK_DIV 4
    send(0, 1, 5);
    chk("cnt_init", 0, int'(dled[0]), 0);
    chk("cnt_busy", 0, int'(dbusy[0]), 1);
    chk("cnt_rdy",  0, int'(rdy[0]), 0);
    cyc(3); chk("cnt_e3", 0, int'(dled[0]), 0);
    cyc(1); chk("cnt_e4", 0, int'(dled[0]), 1);
    cyc(16);
    chk("cnt_hold", 0, int'(dled[0]), 5);
    chk("cnt_done", 0, int'(ddone[0]), 1);
    chk("cnt_nbsy", 0, int'(dbusy[0]), 0);
    cyc(1);
    chk("cnt_done1", 0, int'(ddone[0]), 0);
    chk("cnt_frz",   0, int'(dled[0]), 5);

    // mode 2 endless, 8 steps, then stop
    send(0, 2, 0);
    chk("bnc_init", 0, int'(dled[0]), 1);
    cyc(32); chk("bnc_s8", 0, int'(dled[0]), 4);
    cyc(2);
    stp[0] = 1'b1;
    cyc(1);
    stp[0] = 1'b0;
    chk("stop_led",  0, int'(dled[0]), 0);
    chk("stop_busy", 0, int'(dbusy[0]), 0);
    chk("stop_rdy",  0, int'(rdy[0]), 1);

    // mode 3, len 3, TICK_DIV 1
    send(1, 3, 3);
    chk("blk_0", 1, int'(dled[1]), 15);
    cyc(1); chk("blk_1", 1, int'(dled[1]), 0);
    cyc(1); chk("blk_2", 1, int'(dled[1]), 15);
    cyc(1); chk("blk_3", 1, int'(dled[1]), 0);
    chk("blk_done", 1, int'(ddone[1]), 1);
    cyc(1); chk("blk_done1", 1, int'(ddone[1]), 0);

    // command held during RUN, accepted in first HOLD cycle
    send(0, 1, 2);
    vld[0] = 1'b1; md[0] = 2'd3; ln[0] = 8'd1;
    wait_ready(0);
    chk("held_done", 0, int'(ddone[0]), 1);
    chk("held_led",  0, int'(dled[0]), 2);
    cyc(1);
    vld[0] = 1'b0;
    chk("b2b_led",  0, int'(dled[0]), 15);
    chk("b2b_busy", 0, int'(dbusy[0]), 1);
    chk("b2b_done", 0, int'(ddone[0]), 0);
    cyc(4);
    chk("b2b_hold", 0, int'(dled[0]), 0);
    chk("b2b_dn",   0, int'(ddone[0]), 1);

    // stop and valid together in HOLD: stop wins, command taken next edge
    stp[0] = 1'b1; vld[0] = 1'b1; md[0] = 2'd1; ln[0] = 8'd1;
    cyc(1);
    stp[0] = 1'b0;
    chk("sv_led",  0, int'(dled[0]), 0);
    chk("sv_busy", 0, int'(dbusy[0]), 0);
    chk("sv_rdy",  0, int'(rdy[0]), 1);
    cyc(1);
    vld[0] = 1'b0;
    chk("sv_acc", 0, int'(dbusy[0]), 1);
    cyc(4);
    chk("sv_hold", 0, int'(dled[0]), 1);
    chk("sv_done", 0, int'(ddone[0]), 1);

    // mode 1, len 17, TICK_DIV 1: wraps and holds at 0001
    send(1, 1, 17);
    cyc(15); chk("wrap_f", 1, int'(dled[1]), 15);
    cyc(1);  chk("wrap_0", 1, int'(dled[1]), 0);
    cyc(1);  chk("wrap_1", 1, int'(dled[1]), 1);
    chk("wrap_done", 1, int'(ddone[1]), 1);
    cyc(1);  chk("wrap_frz", 1, int'(dled[1]), 1);

    // asynchronous reset mid-run
    send(0, 1, 0);
    cyc(6);
    #2 reset = 1'b1;
    #1;
    chk("arst_led",  0, int'(dled[0]), 0);
    chk("arst_busy", 0, int'(dbusy[0]), 0);
    chk("arst_rdy",  0, int'(rdy[0]), 1);
    @(negedge clk);
    reset = 1'b0;
    cyc(2);
    chk("post_rst", 0, int'(dbusy[0]), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Sequencing controller for the board's 4-bit LED bank, driven from the top-level `clk`/`reset`. A requester issues a mode and step count over a valid/ready command handshake. The block then steps an LED pattern at a rate set by an internal prescaler, and holds the final pattern when the run completes. It sits between the top-level control logic and the `led[3:0]` outputs, and is the only driver of those outputs.

## Interface
- `TICK_DIV`, default 100000: clocks per pattern step; legal range ≥1.
- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: block can accept a command.
- `cmd_mode` input 2: pattern select.
  - 0 = dark
  - 1 = binary count
  - 2 = bounce
  - 3 = blink
- `cmd_len` input 8: number of steps to run; 0 means run until stopped.
- `stop` input 1: abort the run and return to IDLE.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle pulse on the first HOLD cycle.
- `led` output 4: LED pattern, registered.

## Operation
- **Clock and reset:** one clock, `clk`. `reset` is asynchronous and active-high.
- **Reset values:**
  - state = IDLE
  - `led` = 4'b0000, `busy` = 0, `done` = 0, `cmd_ready` = 1
  - prescaler = 0, step counter = 0, bounce direction = left
- **States:** IDLE, RUN, HOLD. `cmd_ready` = 1 in IDLE and HOLD, 0 in RUN. All outputs are registered.
- **Accept:** a command is accepted when `cmd_valid` and `cmd_ready` are both high on a rising edge. On that edge:
  - state goes to RUN
  - `cmd_mode` and `cmd_len` are latched
  - prescaler and step counter clear
  - `led` loads the initial pattern for the mode
- **Initial patterns:**
  - mode 0: 0000
  - mode 1: 0000
  - mode 2: 0001, direction = left
  - mode 3: 1111
- **Tick:** `tick` is high when prescaler == TICK_DIV-1. The prescaler wraps to 0 on `tick` and counts only in RUN.
- **Step:** on an edge with `tick` high, the LED pattern advances and the step counter increments.
  - mode 0: stays 0000 (acts as a timed delay).
  - mode 1: `led` + 1, modulo 16 (1111 → 0000).
  - mode 2: shift one position in the current direction; direction reverses on reaching 1000 or 0001. Sequence: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, …
  - mode 3: invert (1111 ↔ 0000).
- **RUN → HOLD:** when `cmd_len` ≠ 0 and the step being taken is step number `cmd_len`. The final pattern update happens on the same edge. In HOLD, `led` is frozen and `done` = 1 for the first HOLD cycle only.
- **`cmd_len` = 0:** RUN continues indefinitely. The step counter saturates at 255 and never causes HOLD.
- **HOLD → RUN:** on command accept, same action as from IDLE; the new pattern replaces the held one.
- **`stop`:** when high in RUN or HOLD, the next state is IDLE with `led` = 0000. `stop` takes priority over a simultaneous accept in HOLD (the command is not accepted, and `cmd_ready` must be ignored by the requester that cycle). `stop` in IDLE has no effect.
- **Commands during RUN:** `cmd_valid` is ignored because `cmd_ready` = 0. The requester holds `cmd_valid` and `cmd_mode`/`cmd_len` stable until accepted.
- **Reset mid-run:** the block returns immediately to the reset values. The latched command is discarded.

## Timing
- **Accept-to-pattern latency:** accept on edge N → `led` = initial pattern, `busy` = 1 and `cmd_ready` = 0 from cycle N+1.
- **Step spacing:** each pattern is visible for exactly TICK_DIV cycles. Step k updates on edge N + k·TICK_DIV.
- **Finite run:** with `cmd_len` = L, the last update and the HOLD entry occur on edge N + L·TICK_DIV. `done`, `cmd_ready` = 1 and `busy` = 0 appear in the following cycle.
- **Back-to-back commands:** a command accepted in the first HOLD cycle restarts RUN on the next edge. `done` is still pulsed for exactly one cycle.
- **Stop latency:** `stop` sampled on edge M → IDLE with `led` = 0000 from cycle M+1.
- **TICK_DIV = 1:** one step per clock. Initial pattern for 1 cycle, then a new pattern every cycle.

## Test plan
- Reset, then assert `reset` for 1 cycle mid-RUN → `led` = 0000, `busy` = 0, `cmd_ready` = 1 immediately, without waiting for a clock edge.
- TICK_DIV = 4, mode 1, `cmd_len` = 5 accepted at edge 0 → `led` = 0,1,2,3,4,5 changing at edges 4, 8, 12, 16, 20. HOLD with `led` = 0101 and `done` pulse in the cycle after edge 20.
- TICK_DIV = 4, mode 2, `cmd_len` = 0, run 8 steps → sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100. `stop` at an arbitrary cycle → `led` = 0000 the next cycle.
- TICK_DIV = 1, mode 3, `cmd_len` = 3 → 1111, 0000, 1111, 0000 on consecutive cycles. HOLD at 0000 with a one-cycle `done`.
- `cmd_valid` held during RUN → not accepted until HOLD. Accepted in the first HOLD cycle, and the new mode starts the next cycle.
- HOLD with `stop` and `cmd_valid` both high on the same edge → IDLE, command not accepted. The same command is accepted on the following edge.
- Mode 1 with `cmd_len` = 17 → wraps 1111 → 0000 and holds at 0001.
